// File: rtl/spi_write_pkg.sv
// Shared constants for the SPI write path: FSM state encoding, SPI mode and
// divider defaults, and a helper that sizes the divider counters.
package spi_write_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_SHIFT   = 3'd3;
  localparam state_t ST_CS_HOLD = 3'd4;

  // SPI mode 0: clock idles low, data launched on the trailing edge
  localparam int CPOL = 0;
  localparam int CPHA = 0;

  localparam int DEFAULT_CLK_DIV = 2;

  // Counter width able to hold 0..div-1; at least one bit so CLK_DIV=1 works
  function automatic int div_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: a half-period divider that toggles sclk while enabled and
// reports the leading (rise) and trailing (fall) edge one cycle ahead of the
// registered sclk change, so the FSM can act on the same edge.
module spi_sclk_gen
  import spi_write_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = div_cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic SCLK_IDLE = (CPOL != 0);

  logic [DIV_W-1:0] div_cnt;
  logic             terminal;

  assign terminal = en && (div_cnt == DIV_LAST);
  assign rise     = terminal && (sclk == SCLK_IDLE);
  assign fall     = terminal && (sclk != SCLK_IDLE);

  // Divider and clock toggle; disabling parks sclk at idle and restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      sclk    <= SCLK_IDLE;
    end else if (terminal) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_write_shifter.sv
// SPI write shifter: pops bytes from the write FIFO and shifts them out
// MSB-first in SPI mode 0, one chip-select frame of byte_count bytes per start.
// Stalls in FETCH (sclk low, cs_n held) whenever the FIFO runs dry.
module spi_write_shifter
  import spi_write_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] byte_count,
  input  logic [7:0]           fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n,
  output logic                 busy,
  output logic                 done,
  output logic                 stalled
);

  localparam int DIV_W = div_cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] byte_cnt;
  logic [2:0]           bit_cnt;
  logic [6:0]           shift_reg;   // bits still to send after the one on mosi
  logic [DIV_W-1:0]     hold_cnt;

  logic sclk_en;
  logic sclk_rise;
  logic sclk_fall;
  logic shift_stb;
  logic last_bit;
  logic hold_end;
  logic accept;
  logic zero_req;
  logic cs_n_d;
  logic busy_d;
  logic done_d;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sclk_en),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign sclk_en   = (state_q == ST_SHIFT);
  // Mode 0 launches new data on the trailing edge; the slave samples on the leading one
  assign shift_stb = (CPHA == 0) ? sclk_fall : sclk_rise;
  assign last_bit  = sclk_en && shift_stb && (bit_cnt == 3'd7);
  assign hold_end  = (state_q == ST_CS_HOLD) && (hold_cnt == DIV_LAST);
  assign accept    = (state_q == ST_IDLE) && start && (byte_count != '0);
  assign zero_req  = (state_q == ST_IDLE) && start && (byte_count == '0);

  // State register plus the frame outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_n    <= cs_n_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_FETCH;
      ST_FETCH:   if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_SHIFT;
      ST_SHIFT:   if (last_bit) state_d = (byte_cnt == CNT_WIDTH'(1)) ? ST_CS_HOLD : ST_FETCH;
      ST_CS_HOLD: if (hold_end) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode: FIFO handshake from the registered state, frame outputs from the next state
  always_comb begin
    fifo_rd_en = (state_q == ST_FETCH) && !fifo_empty;
    stalled    = (state_q == ST_FETCH) && fifo_empty;
    cs_n_d     = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = hold_end || zero_req;
  end

  // Byte/bit/hold counters and the mosi launch register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      mosi     <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_count;
      end else if (last_bit) begin
        byte_cnt <= byte_cnt - 1'b1;
      end
      hold_cnt <= ((state_q == ST_CS_HOLD) && !hold_end) ? hold_cnt + 1'b1 : '0;
      if (state_q == ST_LOAD) begin
        mosi    <= fifo_dout[7];
        bit_cnt <= '0;
      end else if (sclk_en && shift_stb) begin
        mosi    <= shift_reg[6];
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Shift register holds data only; its contents are irrelevant until the next LOAD
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) begin
      shift_reg <= fifo_dout[6:0];
    end else if (sclk_en && shift_stb) begin
      shift_reg <= {shift_reg[5:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_write_shifter.sv
// Directed bench for spi_write_shifter: instance 0 runs CLK_DIV=2, instance 1
// runs CLK_DIV=1. A small FIFO model feeds each instance and a bus monitor
// accumulates per-instance event counts that the directed steps compare as deltas.
module tb_spi_write_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [5:0] bcnt [2];
  logic [7:0] fdout [2];
  logic [1:0] fempty;
  logic [1:0] rd_en, sclk, mosi, cs_n, busy, done, stalled;

  int tests = 0;
  int fails = 0;

  // FIFO model: write pointer owned by the stimulus, read pointer by the pop process
  logic [7:0] mem [2][32];
  logic [4:0] wr [2] = '{default: 5'd0};
  logic [4:0] rd [2] = '{default: 5'd0};

  // Bus monitor accumulators
  int          rdp [2]      = '{default: 0};
  int          rdbad [2]    = '{default: 0};
  int          cslow [2]    = '{default: 0};
  int          donec [2]    = '{default: 0};
  int          drise [2]    = '{default: 0};
  int          stallc [2]   = '{default: 0};
  int          sbad [2]     = '{default: 0};
  int          nrise [2]    = '{default: 0};
  int          gaps [2]     = '{default: 0};
  int          gaplen [2]   = '{default: 0};
  int          lowrun [2]   = '{default: 0};
  logic [31:0] bits [2]     = '{default: 32'd0};
  logic [1:0]  seen         = 2'b00;
  logic [1:0]  sprev        = 2'b00;
  logic [1:0]  cprev        = 2'b11;

  int b_rdp, b_cs, b_done, b_drise, b_stall, b_sbad, b_rise;

  always #5 clk = ~clk;

  assign fempty[0] = (wr[0] == rd[0]);
  assign fempty[1] = (wr[1] == rd[1]);

  spi_write_shifter #(.CLK_DIV(2), .CNT_WIDTH(6)) u_div2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .byte_count(bcnt[0]),
    .fifo_dout(fdout[0]), .fifo_empty(fempty[0]), .fifo_rd_en(rd_en[0]),
    .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0]), .busy(busy[0]),
    .done(done[0]), .stalled(stalled[0]));

  spi_write_shifter #(.CLK_DIV(1), .CNT_WIDTH(6)) u_div1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .byte_count(bcnt[1]),
    .fifo_dout(fdout[1]), .fifo_empty(fempty[1]), .fifo_rd_en(rd_en[1]),
    .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1]), .busy(busy[1]),
    .done(done[1]), .stalled(stalled[1]));

  // FIFO pop: data appears the cycle after the read strobe
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) begin
        fdout[k] <= mem[k][rd[k]];
        rd[k]    <= rd[k] + 5'd1;
      end
    end
  end

  // Bus monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) rdp[k] <= rdp[k] + 1;
      if (rd_en[k] && fempty[k]) rdbad[k] <= rdbad[k] + 1;
      if (!cs_n[k]) cslow[k] <= cslow[k] + 1;
      if (done[k]) donec[k] <= donec[k] + 1;
      if (done[k] && cs_n[k] && !cprev[k]) drise[k] <= drise[k] + 1;
      if (stalled[k]) stallc[k] <= stallc[k] + 1;
      if (stalled[k] && (sclk[k] || rd_en[k] || cs_n[k])) sbad[k] <= sbad[k] + 1;
      if (cs_n[k]) begin
        seen[k]   <= 1'b0;
        lowrun[k] <= 0;
      end else if (sclk[k] && !sprev[k]) begin
        nrise[k] <= nrise[k] + 1;
        bits[k]  <= {bits[k][30:0], mosi[k]};
        // a low stretch longer than one half-period marks an inter-byte gap
        if (seen[k] && (lowrun[k] > ((k == 0) ? 2 : 1))) begin
          gaps[k]   <= gaps[k] + 1;
          gaplen[k] <= lowrun[k];
        end
        seen[k]   <= 1'b1;
        lowrun[k] <= 0;
      end else if (!sclk[k]) begin
        lowrun[k] <= lowrun[k] + 1;
      end
      sprev[k] <= sclk[k];
      cprev[k] <= cs_n[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wr[k]] = b;
    wr[k] = wr[k] + 5'd1;
  endtask

  task automatic snap(input int k);
    b_rdp = rdp[k]; b_cs = cslow[k]; b_done = donec[k]; b_drise = drise[k];
    b_stall = stallc[k]; b_sbad = sbad[k]; b_rise = nrise[k];
  endtask

  task automatic pulse_start(input int k, input logic [5:0] n);
    start[k] = 1'b1;
    bcnt[k]  = n;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done[k] && n < budget);
    check({tag, "_done_seen"}, 32'(done[k]), 32'd1);
    check({tag, "_cs_rises_with_done"}, 32'(cs_n[k]), 32'd1);
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 2'b00;
    bcnt[0] = '0;
    bcnt[1] = '0;
    settle(3);

    // Reset state
    check("rst_cs_n", 32'(cs_n[0]), 32'd1);
    check("rst_sclk", 32'(sclk[0]), 32'd0);
    check("rst_mosi", 32'(mosi[0]), 32'd0);
    check("rst_busy_done_stall_rd", {28'd0, busy[0], done[0], stalled[0], rd_en[0]}, 32'd0);
    check("rst_div1_cs_n_busy", {30'd0, cs_n[1], busy[1]}, 32'd2);
    rst_n = 1'b1;
    settle(2);

    // Single byte 0xA5 at CLK_DIV=2
    push(0, 8'hA5);
    snap(0);
    pulse_start(0, 6'd1);
    check("single_busy", 32'(busy[0]), 32'd1);
    check("single_cs_low", 32'(cs_n[0]), 32'd0);
    wait_done(0, 200, "single");
    settle(3);
    check("single_rd_pulses", 32'(rdp[0] - b_rdp), 32'd1);
    check("single_rises", 32'(nrise[0] - b_rise), 32'd8);
    check("single_bits", {24'd0, bits[0][7:0]}, 32'hA5);
    check("single_cs_low_clks", 32'(cslow[0] - b_cs), 32'd36);
    check("single_done_pulses", 32'(donec[0] - b_done), 32'd1);
    check("single_done_at_cs_rise", 32'(drise[0] - b_drise), 32'd1);

    // Burst of 3 at CLK_DIV=1: N*(2+16)+1 = 55 clks of cs_n low
    push(1, 8'h01); push(1, 8'h80); push(1, 8'hFF);
    snap(1);
    pulse_start(1, 6'd3);
    wait_done(1, 300, "burst");
    settle(3);
    check("burst_rd_pulses", 32'(rdp[1] - b_rdp), 32'd3);
    check("burst_rises", 32'(nrise[1] - b_rise), 32'd24);
    check("burst_bits", {8'd0, bits[1][23:0]}, 32'h0180FF);
    check("burst_gaps", 32'(gaps[1]), 32'd2);
    check("burst_gap_low_clks", 32'(gaplen[1]), 32'd3);
    check("burst_cs_low_clks", 32'(cslow[1] - b_cs), 32'd55);

    // Underrun: two bytes requested, one present
    push(0, 8'h11);
    snap(0);
    pulse_start(0, 6'd2);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!stalled[0] && n < 200);
    check("under_stalled", 32'(stalled[0]), 32'd1);
    settle(10);
    check("under_still_stalled", 32'(stalled[0]), 32'd1);
    check("under_cs_sclk", {30'd0, cs_n[0], sclk[0]}, 32'd0);
    check("under_one_read", 32'(rdp[0] - b_rdp), 32'd1);
    check("under_stall_len", 32'((stallc[0] - b_stall) >= 10), 32'd1);
    check("under_stall_quiet", 32'(sbad[0] - b_sbad), 32'd0);
    push(0, 8'h3C);
    wait_done(0, 200, "under");
    settle(3);
    check("under_stall_cleared", 32'(stalled[0]), 32'd0);
    check("under_rd_pulses", 32'(rdp[0] - b_rdp), 32'd2);
    check("under_bits", {16'd0, bits[0][15:0]}, 32'h113C);

    // Zero count: done next cycle, nothing else moves
    snap(0);
    pulse_start(0, 6'd0);
    check("zero_done", 32'(done[0]), 32'd1);
    check("zero_idle", {30'd0, cs_n[0], busy[0]}, 32'd2);
    settle(5);
    check("zero_done_pulses", 32'(donec[0] - b_done), 32'd1);
    check("zero_no_activity", 32'((rdp[0] - b_rdp) + (cslow[0] - b_cs) + (nrise[0] - b_rise)), 32'd0);

    // Reset during bit 4 of 0xC3, then send the next byte 0x5A
    push(0, 8'hC3); push(0, 8'h5A);
    snap(0);
    pulse_start(0, 6'd1);
    n = 0;
    while ((nrise[0] - b_rise) < 4 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rstmid_reached_bit4", 32'(nrise[0] - b_rise), 32'd4);
    rst_n = 1'b0;
    settle(1);
    check("rstmid_cs_n", 32'(cs_n[0]), 32'd1);
    check("rstmid_sclk_busy_done", {29'd0, sclk[0], busy[0], done[0]}, 32'd0);
    rst_n = 1'b1;
    settle(3);
    check("rstmid_no_done", 32'(donec[0] - b_done), 32'd0);
    snap(0);
    pulse_start(0, 6'd1);
    wait_done(0, 200, "rstmid");
    settle(3);
    check("rstmid_next_bits", {24'd0, bits[0][7:0]}, 32'h5A);
    check("rstmid_next_rd", 32'(rdp[0] - b_rdp), 32'd1);

    // Start while busy must not extend the transaction
    push(0, 8'h77); push(0, 8'hE1);
    snap(0);
    pulse_start(0, 6'd1);
    settle(10);
    pulse_start(0, 6'd5);
    wait_done(0, 200, "busy_start");
    settle(60);
    check("busy_start_done_pulses", 32'(donec[0] - b_done), 32'd1);
    check("busy_start_rd", 32'(rdp[0] - b_rdp), 32'd1);
    check("busy_start_bits", {24'd0, bits[0][7:0]}, 32'h77);
    check("busy_start_cs_low_clks", 32'(cslow[0] - b_cs), 32'd36);
    check("busy_start_idle", 32'(busy[0]), 32'd0);

    // Whole-run handshake rules
    check("never_rd_when_empty", 32'(rdbad[0] + rdbad[1]), 32'd0);
    check("stall_outputs_quiet", 32'(sbad[0] + sbad[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
